mips_mc_control: RTL and testbench

Multi-cycle control unit for the MIPS CPU core. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives the program counter's update, jump and branch controls, plus the enables for the instruction register, register file, ALU and memory. It sits between the instruction register/ALU (which supply opcode, funct and zeroFlag) and the `pc` and datapath blocks it controls.

---
 rtl/mips_pkg.sv | 45 ++++
 rtl/mips_opcode_decode.sv | 34 +++
 rtl/mips_mc_control.sv | 147 ++++++++++++++
 tb/tb_mips_mc_control.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct constants, ALU op encodings, control states
// and the instruction classes produced by the decoder.
package mips_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUOP_W = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2a;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_RTYPE = 3'd1,
    CLS_ADDI  = 3'd2,
    CLS_LW    = 3'd3,
    CLS_SW    = 3'd4,
    CLS_BEQ   = 3'd5,
    CLS_J     = 3'd6
  } iclass_e;

endpackage

// File: rtl/mips_opcode_decode.sv
// Combinational opcode/funct classifier; flags anything outside the supported subset.
module mips_opcode_decode
  import mips_pkg::*;
(
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  output iclass_e            iclass,
  output logic               legal
);

  always_comb begin
    iclass = CLS_NONE;
    legal  = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        iclass = CLS_RTYPE;
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: legal = 1'b1;
          default: begin
            iclass = CLS_NONE;
            legal  = 1'b0;
          end
        endcase
      end
      OP_LW:   iclass = CLS_LW;
      OP_SW:   iclass = CLS_SW;
      OP_BEQ:  iclass = CLS_BEQ;
      OP_J:    iclass = CLS_J;
      OP_ADDI: iclass = CLS_ADDI;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/exec/mem/wb and drives
// the PC and datapath strobes; counts retired instructions.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [OP_W-1:0]      opcode,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 zeroFlag,
  input  logic                 memReady,
  output logic                 pcWrite,
  output logic                 jmpFlag,
  output logic                 branchFlag,
  output logic                 irWrite,
  output logic                 memRead,
  output logic                 memWrite,
  output logic                 iorD,
  output logic                 regWrite,
  output logic                 regDst,
  output logic                 memToReg,
  output logic                 aluSrcB,
  output logic [ALUOP_W-1:0]   aluOp,
  output logic                 illegal,
  output logic [CNT_W-1:0]     retired
);

  state_e     state, state_nxt;
  iclass_e    cls, cls_nxt;
  iclass_e    dec_cls;
  logic       dec_legal;
  logic       run;
  logic       retire;

  mips_opcode_decode u_dec (
    .opcode (opcode),
    .funct  (funct),
    .iclass (dec_cls),
    .legal  (dec_legal)
  );

  // run holds the first FETCH request off until the cycle after reset release
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= FETCH;
      cls     <= CLS_NONE;
      run     <= 1'b0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_nxt;
      cls   <= cls_nxt;
      run   <= 1'b1;
      if (state == DECODE && !dec_legal) illegal <= 1'b1;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    cls_nxt    = cls;
    retire     = 1'b0;
    pcWrite    = 1'b0;
    jmpFlag    = 1'b0;
    branchFlag = 1'b0;
    irWrite    = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    iorD       = 1'b0;
    regWrite   = 1'b0;
    regDst     = 1'b0;
    memToReg   = 1'b0;
    aluSrcB    = 1'b0;
    aluOp      = ALUOP_ADD;
    case (state)
      FETCH: begin
        if (run) begin
          memRead = 1'b1;
          if (memReady) begin
            irWrite   = 1'b1;
            pcWrite   = 1'b1;
            state_nxt = DECODE;
          end
        end
      end
      DECODE: begin
        cls_nxt   = dec_cls;
        state_nxt = dec_legal ? EXEC : TRAP;
      end
      EXEC: begin
        case (cls)
          CLS_RTYPE: begin
            aluOp     = ALUOP_FUNCT;
            state_nxt = WB;
          end
          CLS_ADDI: begin
            aluSrcB   = 1'b1;
            state_nxt = WB;
          end
          CLS_LW, CLS_SW: begin
            aluSrcB   = 1'b1;
            state_nxt = MEM;
          end
          CLS_BEQ: begin
            aluOp      = ALUOP_SUB;
            branchFlag = 1'b1;
            pcWrite    = zeroFlag;
            retire     = 1'b1;
            state_nxt  = FETCH;
          end
          CLS_J: begin
            jmpFlag   = 1'b1;
            pcWrite   = 1'b1;
            retire    = 1'b1;
            state_nxt = FETCH;
          end
          default: state_nxt = TRAP;
        endcase
      end
      MEM: begin
        iorD     = 1'b1;
        memRead  = (cls == CLS_LW);
        memWrite = (cls == CLS_SW);
        if (memReady) begin
          if (cls == CLS_LW) begin
            state_nxt = WB;
          end else begin
            retire    = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      WB: begin
        regWrite  = 1'b1;
        regDst    = (cls == CLS_RTYPE);
        memToReg  = (cls == CLS_LW);
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      TRAP: state_nxt = TRAP;
      default: state_nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: per-cycle strobe vectors for each instruction class.
module tb_mips_mc_control;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zeroFlag;
  logic        memReady;
  logic        pcWrite, jmpFlag, branchFlag, irWrite, memRead, memWrite, iorD;
  logic        regWrite, regDst, memToReg, aluSrcB, illegal;
  logic [1:0]  aluOp;
  logic [31:0] retired;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // {pcWrite,jmpFlag,branchFlag,irWrite,memRead,memWrite,iorD,regWrite,regDst,memToReg,aluSrcB,aluOp}
  localparam logic [12:0] V_IDLE   = 13'b0000000000000;
  localparam logic [12:0] V_FETCH  = 13'b1001100000000;
  localparam logic [12:0] V_FSTALL = 13'b0000100000000;
  localparam logic [12:0] V_EX_R   = 13'b0000000000010;
  localparam logic [12:0] V_EX_IMM = 13'b0000000000100;
  localparam logic [12:0] V_WB_R   = 13'b0000000110000;
  localparam logic [12:0] V_WB_I   = 13'b0000000100000;
  localparam logic [12:0] V_WB_LW  = 13'b0000000101000;
  localparam logic [12:0] V_MEM_LW = 13'b0000101000000;
  localparam logic [12:0] V_MEM_SW = 13'b0000011000000;
  localparam logic [12:0] V_BEQ_T  = 13'b1010000000001;
  localparam logic [12:0] V_BEQ_N  = 13'b0010000000001;
  localparam logic [12:0] V_J      = 13'b1100000000000;

  logic [12:0] strobes;
  assign strobes = {pcWrite, jmpFlag, branchFlag, irWrite, memRead, memWrite, iorD,
                    regWrite, regDst, memToReg, aluSrcB, aluOp};

  mips_mc_control #(.CNT_W(32)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .opcode     (opcode),
    .funct      (funct),
    .zeroFlag   (zeroFlag),
    .memReady   (memReady),
    .pcWrite    (pcWrite),
    .jmpFlag    (jmpFlag),
    .branchFlag (branchFlag),
    .irWrite    (irWrite),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .iorD       (iorD),
    .regWrite   (regWrite),
    .regDst     (regDst),
    .memToReg   (memToReg),
    .aluSrcB    (aluSrcB),
    .aluOp      (aluOp),
    .illegal    (illegal),
    .retired    (retired)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Check the strobe vector mid-cycle, then advance to 2ns after the next rising edge.
  task automatic cyc(input string tag, input logic [12:0] exp);
    #1;
    check(tag, 32'(strobes), 32'(exp));
    @(posedge Clk);
    #2;
  endtask

  initial begin
    Reset    = 1'b0;
    opcode   = 6'h00;
    funct    = 6'h20;
    zeroFlag = 1'b0;
    memReady = 1'b1;
    repeat (2) @(posedge Clk);
    #3;
    check("rst_strobes", 32'(strobes), 32'(V_IDLE));
    check("rst_retired", retired, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    #2;
    Reset = 1'b1;
    cyc("rel_idle", V_IDLE);

    // add
    cyc("add_fetch", V_FETCH);
    cyc("add_decode", V_IDLE);
    cyc("add_exec", V_EX_R);
    cyc("add_wb", V_WB_R);
    check("add_retired", retired, 32'd1);

    // lw: 2 FETCH stalls, 3 MEM stalls; opcode changes after DECODE are ignored
    opcode = 6'h23;
    memReady = 1'b0;
    cyc("lw_fstall0", V_FSTALL);
    cyc("lw_fstall1", V_FSTALL);
    memReady = 1'b1;
    cyc("lw_fetch", V_FETCH);
    cyc("lw_decode", V_IDLE);
    opcode = 6'h3f;
    cyc("lw_exec", V_EX_IMM);
    memReady = 1'b0;
    cyc("lw_mstall0", V_MEM_LW);
    cyc("lw_mstall1", V_MEM_LW);
    check("lw_mid_retired", retired, 32'd1);
    cyc("lw_mstall2", V_MEM_LW);
    memReady = 1'b1;
    cyc("lw_mem", V_MEM_LW);
    cyc("lw_wb", V_WB_LW);
    check("lw_retired", retired, 32'd2);
    check("lw_illegal", 32'(illegal), 32'd0);

    // sw
    opcode = 6'h2b;
    cyc("sw_fetch", V_FETCH);
    cyc("sw_decode", V_IDLE);
    cyc("sw_exec", V_EX_IMM);
    cyc("sw_mem", V_MEM_SW);
    check("sw_retired", retired, 32'd3);

    // beq taken then not taken
    opcode = 6'h04;
    zeroFlag = 1'b1;
    cyc("beqt_fetch", V_FETCH);
    cyc("beqt_decode", V_IDLE);
    cyc("beqt_exec", V_BEQ_T);
    check("beqt_retired", retired, 32'd4);
    zeroFlag = 1'b0;
    cyc("beqn_fetch", V_FETCH);
    cyc("beqn_decode", V_IDLE);
    cyc("beqn_exec", V_BEQ_N);
    check("beqn_retired", retired, 32'd5);

    // j, then FETCH immediately follows
    opcode = 6'h02;
    cyc("j_fetch", V_FETCH);
    cyc("j_decode", V_IDLE);
    cyc("j_exec", V_J);
    check("j_retired", retired, 32'd6);

    // addi
    opcode = 6'h08;
    cyc("addi_fetch", V_FETCH);
    cyc("addi_decode", V_IDLE);
    cyc("addi_exec", V_EX_IMM);
    cyc("addi_wb", V_WB_I);
    check("addi_retired", retired, 32'd7);

    // sw abandoned by reset during MEM
    opcode = 6'h2b;
    memReady = 1'b0;
    cyc("swr_fstall", V_FSTALL);
    memReady = 1'b1;
    cyc("swr_fetch", V_FETCH);
    cyc("swr_decode", V_IDLE);
    cyc("swr_exec", V_EX_IMM);
    memReady = 1'b0;
    #1;
    check("swr_mem", 32'(strobes), 32'(V_MEM_SW));
    #2;
    Reset = 1'b0;
    #1;
    check("swr_async_drop", 32'(strobes), 32'(V_IDLE));
    check("swr_retired", retired, 32'd0);
    @(posedge Clk);
    #2;
    Reset = 1'b1;
    memReady = 1'b1;
    opcode = 6'h00;
    funct = 6'h22;
    cyc("swr_rel_idle", V_IDLE);
    cyc("sub_fetch", V_FETCH);
    cyc("sub_decode", V_IDLE);
    cyc("sub_exec", V_EX_R);
    cyc("sub_wb", V_WB_R);
    check("sub_retired", retired, 32'd1);

    // illegal opcode: absorbing TRAP
    opcode = 6'h3f;
    cyc("ill_fetch", V_FETCH);
    check("ill_pre", 32'(illegal), 32'd0);
    cyc("ill_decode", V_IDLE);
    check("ill_set", 32'(illegal), 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (strobes !== V_IDLE || illegal !== 1'b1) begin
        check("ill_trap_hold", {19'd0, illegal, strobes}, {19'd0, 1'b1, V_IDLE});
      end
      @(posedge Clk);
      #2;
    end
    check("ill_trap_end", {19'd0, illegal, strobes}, {19'd0, 1'b1, V_IDLE});
    check("ill_retired", retired, 32'd1);
    Reset = 1'b0;
    #1;
    check("ill_clear", 32'(illegal), 32'd0);
    @(posedge Clk);
    #2;
    Reset = 1'b1;

    // illegal R-type funct
    opcode = 6'h00;
    funct = 6'h3f;
    cyc("illf_idle", V_IDLE);
    cyc("illf_fetch", V_FETCH);
    cyc("illf_decode", V_IDLE);
    cyc("illf_trap", V_IDLE);
    check("illf_set", 32'(illegal), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
